// File: rtl/alu_pkg.sv
// Shared definitions for the execute-stage arithmetic units.
// - Op encodings follow RV32M funct3.
// - ST_* is the state encoding of the sequential multiply/divide FSM.
// - is_div() picks out the divide half of the opcode space.
package alu_pkg;

  localparam logic [2:0] OP_MUL    = 3'b000;
  localparam logic [2:0] OP_MULH   = 3'b001;
  localparam logic [2:0] OP_MULHSU = 3'b010;
  localparam logic [2:0] OP_MULHU  = 3'b011;
  localparam logic [2:0] OP_DIV    = 3'b100;
  localparam logic [2:0] OP_DIVU   = 3'b101;
  localparam logic [2:0] OP_REM    = 3'b110;
  localparam logic [2:0] OP_REMU   = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  function automatic logic is_div(input logic [2:0] op);
    return op[2];
  endfunction

endpackage

// File: rtl/muldiv_seq_if.sv
// Request/response bundle of the sequential multiply/divide unit.
// - in_valid/in_ready with op, input_a, input_b : request handshake
// - out_valid/out_ready with out, is_zero       : response handshake
// - busy                                        : unit is working or holding a result
// master = requester (execute stage), slave = muldiv_seq.
interface muldiv_seq_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [2:0]      op;
  logic [XLEN-1:0] input_a;
  logic [XLEN-1:0] input_b;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out;
  logic            is_zero;
  logic            busy;

  modport master (
    output in_valid, op, input_a, input_b, out_ready,
    input  in_ready, out_valid, out, is_zero, busy
  );

  modport slave (
    input  in_valid, op, input_a, input_b, out_ready,
    output in_ready, out_valid, out, is_zero, busy
  );
endinterface

// File: rtl/muldiv_seq.sv
// Iterative RV32M multiply/divide unit (radix-2 shift-add / restoring divide).
// Ports:
// - clk   : rising-edge clock
// - rst_n : asynchronous active-low reset
// - bus   : muldiv_seq_if.slave request/response handshake, out, is_zero, busy
// Operands are converted to magnitudes when accepted; the sign is put back on
// the edge that enters DONE. Divide by zero and signed overflow bypass CALC.
module muldiv_seq
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  muldiv_seq_if.slave  bus
);

  localparam int CNT_W = $clog2(XLEN + 1);
  localparam logic [XLEN-1:0] MIN_VAL = {1'b1, {(XLEN-1){1'b0}}};

  state_t            r_state;
  state_t            w_state_next;
  logic [2:0]        r_op;
  logic [XLEN-1:0]   r_d;          // multiplicand (mul) or divisor (div) magnitude
  logic [2*XLEN-1:0] r_acc;        // {hi, lo}: product / {remainder, quotient}
  logic [CNT_W-1:0]  r_cnt;
  logic              r_neg;        // final result must be negated
  logic [XLEN-1:0]   r_out;
  logic              r_is_zero;

  // ---------------- accept-time decode ----------------
  logic            w_accept;
  logic            w_a_signed;
  logic            w_b_signed;
  logic            w_neg_a;
  logic            w_neg_b;
  logic [XLEN-1:0] w_mag_a;
  logic [XLEN-1:0] w_mag_b;
  logic            w_b_zero;
  logic            w_ovf;
  logic            w_special;
  logic [XLEN-1:0] w_special_res;
  logic            w_neg_res;

  assign w_accept   = bus.in_valid && (r_state == ST_IDLE);
  assign w_a_signed = (bus.op != OP_MULHU) && (bus.op != OP_DIVU) && (bus.op != OP_REMU);
  assign w_b_signed = w_a_signed && (bus.op != OP_MULHSU);
  assign w_neg_a    = w_a_signed && bus.input_a[XLEN-1];
  assign w_neg_b    = w_b_signed && bus.input_b[XLEN-1];
  assign w_mag_a    = w_neg_a ? -bus.input_a : bus.input_a;
  assign w_mag_b    = w_neg_b ? -bus.input_b : bus.input_b;

  assign w_b_zero  = (bus.input_b == '0);
  assign w_ovf     = ((bus.op == OP_DIV) || (bus.op == OP_REM)) &&
                     (bus.input_a == MIN_VAL) && (bus.input_b == '1);
  assign w_special = is_div(bus.op) && (w_b_zero || w_ovf);
  // op[1] selects the remainder flavour within the divide group
  assign w_special_res = w_b_zero ? (bus.op[1] ? bus.input_a : '1)
                                  : (bus.op[1] ? '0 : MIN_VAL);
  // remainder follows the dividend's sign; everything else is sign(a)^sign(b)
  assign w_neg_res = (is_div(bus.op) && bus.op[1]) ? w_neg_a : (w_neg_a ^ w_neg_b);

  // ---------------- one iteration, shared XLEN+1-bit adder ----------------
  logic [XLEN-1:0]   w_hi;
  logic [XLEN-1:0]   w_lo;
  logic              w_div;
  logic [XLEN:0]     w_add_a;
  logic [XLEN:0]     w_add_b;
  logic [XLEN:0]     w_sum;
  logic [2*XLEN-1:0] w_acc_next;
  logic              w_last;

  assign w_hi  = r_acc[2*XLEN-1:XLEN];
  assign w_lo  = r_acc[XLEN-1:0];
  assign w_div = is_div(r_op);

  // Divide: trial-subtract divisor from {rem, next dividend bit}.
  // Multiply: add multiplicand into the high half when the multiplier bit is 1.
  assign w_add_a = w_div ? {w_hi, w_lo[XLEN-1]} : {1'b0, w_hi};
  assign w_add_b = w_div ? ~{1'b0, r_d} : (w_lo[0] ? {1'b0, r_d} : '0);
  assign w_sum   = w_add_a + w_add_b + {{XLEN{1'b0}}, w_div};

  // w_sum[XLEN] is the borrow of the trial subtraction: restore on borrow
  assign w_acc_next = w_div
      ? (w_sum[XLEN] ? {w_add_a[XLEN-1:0], w_lo[XLEN-2:0], 1'b0}
                     : {w_sum[XLEN-1:0],   w_lo[XLEN-2:0], 1'b1})
      : {w_sum, w_lo[XLEN-1:1]};

  assign w_last = (r_cnt == CNT_W'(XLEN - 1));

  // ---------------- final sign fix-up on the CALC->DONE edge ----------------
  logic [2*XLEN-1:0] w_prod;
  logic [XLEN-1:0]   w_div_sel;
  logic [XLEN-1:0]   w_div_res;
  logic [XLEN-1:0]   w_final;

  assign w_prod    = r_neg ? -w_acc_next : w_acc_next;
  assign w_div_sel = r_op[1] ? w_acc_next[2*XLEN-1:XLEN] : w_acc_next[XLEN-1:0];
  assign w_div_res = r_neg ? -w_div_sel : w_div_sel;
  assign w_final   = w_div ? w_div_res
                   : ((r_op == OP_MUL) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN]);

  // ---------------- FSM ----------------
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (w_accept) w_state_next = w_special ? ST_DONE : ST_CALC;
      ST_CALC: if (w_last) w_state_next = ST_DONE;
      ST_DONE: if (bus.out_ready) w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // ---------------- datapath ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_op      <= '0;
      r_d       <= '0;
      r_acc     <= '0;
      r_cnt     <= '0;
      r_neg     <= 1'b0;
      r_out     <= '0;
      r_is_zero <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_op  <= bus.op;
            r_neg <= w_neg_res;
            r_cnt <= '0;
            if (is_div(bus.op)) begin
              r_d   <= w_mag_b;
              r_acc <= {{XLEN{1'b0}}, w_mag_a};
            end else begin
              r_d   <= w_mag_a;
              r_acc <= {{XLEN{1'b0}}, w_mag_b};
            end
            if (w_special) begin
              r_out     <= w_special_res;
              r_is_zero <= (w_special_res == '0);
            end
          end
        end
        ST_CALC: begin
          r_acc <= w_acc_next;
          r_cnt <= r_cnt + CNT_W'(1);
          if (w_last) begin
            r_out     <= w_final;
            r_is_zero <= (w_final == '0);
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.in_ready  = (r_state == ST_IDLE);
  assign bus.out_valid = (r_state == ST_DONE);
  assign bus.busy      = (r_state != ST_IDLE);
  assign bus.out       = r_out;
  assign bus.is_zero   = r_is_zero;

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq (XLEN=32): expected results are pushed to
// a scoreboard queue at issue time and popped when out_valid appears.
module tb_muldiv_seq;
  import alu_pkg::*;

  localparam int XLEN = 32;
  localparam logic [31:0] MINV = 32'h8000_0000;

  logic clk;
  logic rst_n;

  muldiv_seq_if #(.XLEN(XLEN)) bus ();

  muldiv_seq #(.XLEN(XLEN)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic        z;
    int          lat;
  } exp_t;

  exp_t exp_q[$];
  int   n_total = 0;
  int   n_bad   = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Reference behaviour from 64-bit integer arithmetic.
  function automatic exp_t model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t        e;
    longint      sa, sb, ub;
    logic [63:0] p;
    logic [63:0] ua64, ub64;
    logic        special;
    sa   = longint'($signed(a));
    sb   = longint'($signed(b));
    ub   = longint'({32'd0, b});
    ua64 = {32'd0, a};
    ub64 = {32'd0, b};
    special = op[2] && ((b == 32'd0) ||
              (((op == OP_DIV) || (op == OP_REM)) && (a == MINV) && (b == 32'hffff_ffff)));
    case (op)
      OP_MUL:    begin p = sa * sb;     e.res = p[31:0];  end
      OP_MULH:   begin p = sa * sb;     e.res = p[63:32]; end
      OP_MULHSU: begin p = sa * ub;     e.res = p[63:32]; end
      OP_MULHU:  begin p = ua64 * ub64; e.res = p[63:32]; end
      OP_DIV: begin
        if (b == 32'd0) e.res = 32'hffff_ffff;
        else if (special) e.res = MINV;
        else begin p = sa / sb; e.res = p[31:0]; end
      end
      OP_REM: begin
        if (b == 32'd0) e.res = a;
        else if (special) e.res = 32'd0;
        else begin p = sa % sb; e.res = p[31:0]; end
      end
      OP_DIVU: e.res = (b == 32'd0) ? 32'hffff_ffff : a / b;
      default: e.res = (b == 32'd0) ? a : a % b;
    endcase
    e.z   = (e.res == 32'd0);
    e.lat = special ? 1 : XLEN + 1;
    return e;
  endfunction

  // Drive one request; returns #1 after the accept edge.
  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    int w;
    exp_q.push_back(model(op, a, b));
    @(negedge clk);
    w = 0;
    while (!bus.in_ready && w < 100) begin
      @(negedge clk);
      w++;
    end
    if (w >= 100) check("in_ready timeout", 64'(w), 64'd0);
    bus.in_valid = 1'b1;
    bus.op       = op;
    bus.input_a  = a;
    bus.input_b  = b;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    // scramble operands: the unit must have latched them at accept
    bus.op       = 3'($urandom);
    bus.input_a  = $urandom;
    bus.input_b  = $urandom;
  endtask

  // Wait for the result, compare, optionally stall, then complete the handshake.
  task automatic collect(input string tag, input int hold);
    int          lat;
    exp_t        e;
    logic [31:0] held;
    lat = 1;
    while (!bus.out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (exp_q.size() == 0) begin
      check({tag, " sb_empty"}, 64'd1, 64'd0);
      return;
    end
    e = exp_q.pop_front();
    check({tag, " lat"}, 64'(lat), 64'(e.lat));
    check({tag, " out"}, 64'(bus.out), 64'(e.res));
    check({tag, " zero"}, 64'(bus.is_zero), 64'(e.z));
    $display("txn %s out=%08h zero=%0d lat=%0d", tag, bus.out, bus.is_zero, lat);
    held = bus.out;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      check({tag, " hold_out"}, 64'(bus.out), 64'(held));
      check({tag, " hold_valid"}, 64'(bus.out_valid), 64'd1);
      check({tag, " hold_in_ready"}, 64'(bus.in_ready), 64'd0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    check({tag, " idle_in_ready"}, 64'(bus.in_ready), 64'd1);
    check({tag, " idle_valid"}, 64'(bus.out_valid), 64'd0);
  endtask

  task automatic run(input string tag, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    issue(op, a, b);
    collect(tag, 0);
  endtask

  initial begin
    int          seen;
    logic [2:0]  rop;
    logic [31:0] ra, rb;

    rst_n         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.op        = 3'd0;
    bus.input_a   = '0;
    bus.input_b   = '0;
    bus.out_ready = 1'b0;

    #2;
    check("rst in_ready", 64'(bus.in_ready), 64'd1);
    check("rst out_valid", 64'(bus.out_valid), 64'd0);
    check("rst busy", 64'(bus.busy), 64'd0);
    check("rst out", 64'(bus.out), 64'd0);
    check("rst zero", 64'(bus.is_zero), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    run("mul_4x8",     OP_MUL,    32'h0000_0004, 32'h0000_0008);
    run("mulh_m1x1",   OP_MULH,   32'hffff_ffff, 32'h0000_0001);
    run("mulhu_m1x1",  OP_MULHU,  32'hffff_ffff, 32'h0000_0001);
    run("mulhsu_m1x1", OP_MULHSU, 32'hffff_ffff, 32'h0000_0001);
    run("div_m7_2",    OP_DIV,    32'hffff_fff9, 32'h0000_0002);
    run("rem_m7_2",    OP_REM,    32'hffff_fff9, 32'h0000_0002);
    run("div_ovf",     OP_DIV,    MINV,          32'hffff_ffff);
    run("rem_ovf",     OP_REM,    MINV,          32'hffff_ffff);
    run("divu_by0",    OP_DIVU,   32'h0000_ffff, 32'h0000_0000);
    run("remu_by0",    OP_REMU,   32'h0000_ffff, 32'h0000_0000);
    run("div_by0",     OP_DIV,    32'h8000_0001, 32'h0000_0000);
    run("rem_by0",     OP_REM,    32'h8000_0001, 32'h0000_0000);
    run("divu_big",    OP_DIVU,   MINV,          32'h0000_0003);
    run("rem_7_m3",    OP_REM,    32'h0000_0007, 32'hffff_fffd);
    run("mulhu_max",   OP_MULHU,  32'hffff_ffff, 32'hffff_ffff);

    // backpressure: result held for five cycles, then a fresh MUL
    issue(OP_MULH, 32'h1234_5678, 32'h9abc_def0);
    collect("bp_mulh", 5);
    run("bp_next_mul", OP_MUL, 32'h0001_0003, 32'h0000_0007);

    // reset in the middle of CALC
    issue(OP_MUL, 32'h0000_0003, 32'h0000_0005);
    repeat (10) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst out_valid", 64'(bus.out_valid), 64'd0);
    check("midrst in_ready", 64'(bus.in_ready), 64'd1);
    check("midrst busy", 64'(bus.busy), 64'd0);
    check("midrst out", 64'(bus.out), 64'd0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    exp_q.delete();
    seen = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) seen++;
    end
    check("midrst stale", 64'(seen), 64'd0);
    run("post_rst_mulhu", OP_MULHU, 32'hffff_ffff, 32'hffff_ffff);

    // random mix; divisors shifted down so quotients are non-trivial
    for (int i = 0; i < 16; i++) begin
      rop = 3'($urandom);
      ra  = $urandom;
      rb  = $urandom >> $urandom_range(0, 31);
      if (i % 5 == 4) rb = 32'd0;
      run($sformatf("rnd%0d_op%0d", i, rop), rop, ra, rb);
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
